// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - fixed-latency CPU memory bus controller for a 256x16 RAM plus LED/SW registers
// Optional MMIO decode of LED (9'h100) and SW (9'h140) is enabled by defining MEM_BUS_MMIO_EN.
module mem_bus_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        mem_ready,
    output logic        mem_err,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  sw,
    output logic [7:0]  led
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        cmd_wr_q;
    logic [8:0]  addr_q;
    logic [15:0] data_q;
    logic        mem_ready_q;
    logic        mem_err_q;
    logic        ram_we_q;
    logic [15:0] read_data_q;
    logic [7:0]  led_q;

    logic        cmd_valid;
    logic        sel_ram;
    logic        sel_led;
    logic        acc_err;
    logic [15:0] read_data_d;

    assign cmd_valid = (mem_cmd == 2'b01) || (mem_cmd == 2'b10);

    // Decode works on the latched address so bus changes after acceptance are ignored.
`ifdef MEM_BUS_MMIO_EN
    logic sel_sw;

    always_comb begin
        sel_ram     = !addr_q[8];
        sel_led     = (addr_q == 9'h100);
        sel_sw      = (addr_q == 9'h140);
        acc_err     = !(sel_ram || sel_led || sel_sw) || (cmd_wr_q && sel_sw);
        read_data_d = 16'h0000;
        if (sel_ram) begin
            read_data_d = ram_dout;
        end else if (sel_led) begin
            read_data_d = {8'h00, led_q};
        end else if (sel_sw) begin
            read_data_d = {8'h00, sw};
        end
    end
`else
    logic unused_mmio;

    always_comb begin
        sel_ram     = 1'b1;
        sel_led     = 1'b0;
        acc_err     = 1'b0;
        read_data_d = ram_dout;
    end

    assign unused_mmio = ^{sw, addr_q[8]};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            cmd_wr_q    <= 1'b0;
            addr_q      <= 9'h000;
            data_q      <= 16'h0000;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            read_data_q <= 16'h0000;
            led_q       <= 8'h00;
        end else begin
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_wr_q <= (mem_cmd == 2'b10);
                        addr_q   <= mem_addr;
                        data_q   <= write_data;
                        cnt_q    <= WAIT_LOAD;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q     <= S_RESP;
                        mem_ready_q <= 1'b1;
                        mem_err_q   <= acc_err;
                        ram_we_q    <= cmd_wr_q && sel_ram && !acc_err;
                        if (!cmd_wr_q) begin
                            read_data_q <= read_data_d;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    if (cmd_wr_q && sel_led) begin
                        led_q <= data_q[7:0];
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_addr  = (state_q == S_IDLE) ? mem_addr[7:0] : addr_q[7:0];
    assign ram_din   = data_q;
    assign ram_we    = ram_we_q;
    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;
    assign read_data = read_data_q;
    assign led       = led_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - directed self-checking bench for mem_bus_ctrl (WAIT_CYCLES 1 and 3)
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  sw;
    logic [1:0]  c1, c3;
    logic [8:0]  a1, a3;
    logic [15:0] wd1, wd3;
    logic [15:0] rd1, rd3, din1, din3, dout1, dout3;
    logic        rdy1, rdy3, err1, err3, we1, we3;
    logic [7:0]  ra1, ra3, led1, led3;

    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    int          we1_cnt = 0;

    int checks   = 0;
    int failures = 0;

    mem_bus_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .mem_cmd(c1), .mem_addr(a1), .write_data(wd1),
        .read_data(rd1), .mem_ready(rdy1), .mem_err(err1), .ram_addr(ra1),
        .ram_din(din1), .ram_we(we1), .ram_dout(dout1), .sw(sw), .led(led1)
    );

    mem_bus_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .mem_cmd(c3), .mem_addr(a3), .write_data(wd3),
        .read_data(rd3), .mem_ready(rdy3), .mem_err(err3), .ram_addr(ra3),
        .ram_din(din3), .ram_we(we3), .ram_dout(dout3), .sw(sw), .led(led3)
    );

    always @(posedge clk) begin
        if (we1) begin
            mem1[ra1] <= din1;
            we1_cnt   <= we1_cnt + 1;
        end
        dout1 <= mem1[ra1];
    end

    always @(posedge clk) begin
        if (we3) mem3[ra3] <= din3;
        dout3 <= mem3[ra3];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit use3, input logic [1:0] cmd, input logic [8:0] addr,
                         input logic [15:0] data);
        if (use3) begin
            c3 = cmd; a3 = addr; wd3 = data;
        end else begin
            c1 = cmd; a1 = addr; wd1 = data;
        end
    endtask

    // Issues one command, scrambles the bus right after acceptance, and captures the response cycle.
    task automatic access(input bit use3, input logic [1:0] cmd, input logic [8:0] addr,
                          input logic [15:0] data, output int lat, output logic err,
                          output logic we, output logic [7:0] ra, output logic [15:0] rd,
                          output logic [15:0] din);
        lat = 0; err = 1'bx; we = 1'bx; ra = 8'hxx; rd = 16'hxxxx; din = 16'hxxxx;
        @(negedge clk);
        drive(use3, cmd, addr, data);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) drive(use3, 2'b00, ~addr, ~data);
            if (use3 ? rdy3 : rdy1) begin
                lat = n;
                err = use3 ? err3 : err1;
                we  = use3 ? we3  : we1;
                ra  = use3 ? ra3  : ra1;
                rd  = use3 ? rd3  : rd1;
                din = use3 ? din3 : din1;
                break;
            end
        end
    endtask

    int          lat;
    logic        err, we;
    logic [7:0]  ra;
    logic [15:0] rd, din;
    int          seen;
    int          we_before;

    initial begin
        reset = 1'b0;
        c1 = 2'b00; c3 = 2'b00; a1 = '0; a3 = '0; wd1 = '0; wd3 = '0;
        sw = 8'h3C;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 16'h0000;
            mem3[i] = 16'h0000;
        end
        mem1[8'h10] = 16'hBEEF;
        mem3[8'hFF] = 16'h7E57;
        repeat (3) @(negedge clk);
        check("rst_ready", rdy1, 0);
        check("rst_err", err1, 0);
        check("rst_we", we1, 0);
        check("rst_rdata", rd1, 0);
        check("rst_led", led1, 0);
        check("rst_rdata_w3", rd3, 0);
        reset = 1'b1;
        @(negedge clk);

        // Command 11 must never start an access; RAM address follows the bus while idle.
        c1 = 2'b11; a1 = 9'h033;
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy1) seen++;
        end
        check("cmd11_ignored", seen, 0);
        check("idle_ram_addr", ra1, 8'h33);
        c1 = 2'b00;

        access(0, 2'b10, 9'h005, 16'hABCD, lat, err, we, ra, rd, din);
        check("wr_latency", lat, 2);
        check("wr_ram_we", we, 1);
        check("wr_ram_addr", ra, 8'h05);
        check("wr_ram_din", din, 16'hABCD);
        check("wr_err", err, 0);
        check("wr_rdata_untouched", rd, 16'h0000);
        @(negedge clk);
        check("ready_one_cycle", rdy1, 0);
        check("we_one_cycle", we1, 0);

        access(0, 2'b01, 9'h005, 16'h0000, lat, err, we, ra, rd, din);
        check("rd_latency", lat, 2);
        check("rd_data", rd, 16'hABCD);
        check("rd_no_we", we, 0);

        access(0, 2'b10, 9'h006, 16'h0F0F, lat, err, we, ra, rd, din);
        check("rdata_hold_on_write", rd, 16'hABCD);

        access(1, 2'b01, 9'h0FF, 16'h0000, lat, err, we, ra, rd, din);
        check("w3_rd_latency", lat, 4);
        check("w3_ram_addr_latched", ra, 8'hFF);
        check("w3_rd_data", rd, 16'h7E57);

        // Reset arriving in the WAIT state of a write must abandon it.
        @(negedge clk);
        we_before = we1_cnt;
        drive(0, 2'b10, 9'h010, 16'h1111);
        @(posedge clk);
        @(negedge clk);
        c1 = 2'b00;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rstwait_ready", rdy1, 0);
        check("rstwait_we", we1, 0);
        check("rstwait_err", err1, 0);
        check("rstwait_rdata", rd1, 0);
        check("rstwait_led", led1, 0);
        check("rstwait_no_ram_write", we1_cnt - we_before, 0);
        reset = 1'b1;
        access(0, 2'b01, 9'h010, 16'h0000, lat, err, we, ra, rd, din);
        check("rstwait_rd_latency", lat, 2);
        check("rstwait_ram_kept", rd, 16'hBEEF);

`ifdef MEM_BUS_MMIO_EN
        access(0, 2'b10, 9'h100, 16'h005A, lat, err, we, ra, rd, din);
        check("led_wr_err", err, 0);
        check("led_wr_no_ram_we", we, 0);
        @(negedge clk);
        check("led_value", led1, 8'h5A);
        access(0, 2'b01, 9'h140, 16'h0000, lat, err, we, ra, rd, din);
        check("sw_rd_data", rd, 16'h003C);
        check("sw_rd_err", err, 0);
        access(0, 2'b01, 9'h100, 16'h0000, lat, err, we, ra, rd, din);
        check("led_rd_data", rd, 16'h005A);
        access(0, 2'b01, 9'h1F0, 16'h0000, lat, err, we, ra, rd, din);
        check("unmapped_rd_err", err, 1);
        check("unmapped_rd_data", rd, 16'h0000);
        access(0, 2'b10, 9'h140, 16'h00FF, lat, err, we, ra, rd, din);
        check("sw_wr_err", err, 1);
        check("sw_wr_no_ram_we", we, 0);
        @(negedge clk);
        check("sw_wr_led_kept", led1, 8'h5A);
`else
        access(0, 2'b10, 9'h105, 16'h1234, lat, err, we, ra, rd, din);
        check("nommio_wr_we", we, 1);
        check("nommio_wr_ram_addr", ra, 8'h05);
        check("nommio_wr_err", err, 0);
        @(negedge clk);
        check("nommio_led", led1, 8'h00);
        access(0, 2'b01, 9'h005, 16'h0000, lat, err, we, ra, rd, din);
        check("nommio_ram_data", rd, 16'h1234);
        access(0, 2'b01, 9'h1F0, 16'h0000, lat, err, we, ra, rd, din);
        check("nommio_hi_rd_err", err, 0);
        check("nommio_hi_rd_data", rd, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
